// File: rtl/piso_tx_pkg.sv
// Shared types for the PISO transmit arbiter.
// FSM state encoding and counter width helper.
package piso_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_PARITY
  } state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/piso_shift_core.sv
// WIDTH-bit right-shift register, zero fill, LSB out.
// Load and shift are mutually exclusive enables.
module piso_shift_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             serial_out
);

  logic [WIDTH-1:0] shreg_d;
  logic [WIDTH-1:0] shreg_q;

  always_comb begin
    shreg_d = shreg_q;
    unique case (1'b1)
      load:    shreg_d = din;
      shift:   shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
      default: shreg_d = shreg_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign serial_out = shreg_q[0];

endmodule

// File: rtl/piso_tx_arbiter.sv
// Round-robin transmit arbiter over a shared PISO shifter.
// Define PISO_TX_ARB_PARITY_EN to append an even-parity bit.
module piso_tx_arbiter
  import piso_tx_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   data_in,
  output logic [NUM_REQ-1:0]         ack,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       serial_out,
  output logic                       serial_valid,
  output logic                       frame_done,
  output logic                       busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
  localparam logic [IDW-1:0] RST_LAST = IDW'(NUM_REQ - 1);
  localparam logic [IDW:0]   NREQ     = (IDW+1)'(NUM_REQ);

  state_e         state_d, state_q;
  logic [IDW-1:0] last_d, last_q;
  logic [IDW-1:0] gid_d, gid_q;
  logic [CW-1:0]  cnt_d, cnt_q;

  logic           found;
  logic [IDW-1:0] win;
  logic [IDW:0]   idx;
  logic [WIDTH-1:0] word;
  logic           load;
  logic           shift;
  logic           sh_bit;

  // Search upward from last_q+1 with wrap; first hit wins.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = {1'b0, last_q} + (IDW+1)'(i);
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!found && req[idx[IDW-1:0]]) begin
        found = 1'b1;
        win   = idx[IDW-1:0];
      end
    end
  end

  assign word = data_in[int'(win)*WIDTH +: WIDTH];

`ifdef PISO_TX_ARB_PARITY_EN
  logic par_d, par_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
`ifdef PISO_TX_ARB_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          load    = 1'b1;
          gid_d   = win;
          last_d  = win;
          cnt_d   = '0;
          state_d = ST_SHIFT;
`ifdef PISO_TX_ARB_PARITY_EN
          par_d   = ^word;
`endif
        end
      end
      ST_SHIFT: begin
        shift = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
`ifdef PISO_TX_ARB_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef PISO_TX_ARB_PARITY_EN
      ST_PARITY: state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      last_q  <= RST_LAST;
      gid_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
    end
  end

  piso_shift_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .shift     (shift),
    .din       (word),
    .serial_out(sh_bit)
  );

  // Outputs decode registered state only.
  always_comb begin
    ack          = '0;
    serial_out   = 1'b0;
    serial_valid = 1'b0;
    frame_done   = 1'b0;
    unique case (state_q)
      ST_SHIFT: begin
        serial_out   = sh_bit;
        serial_valid = 1'b1;
        if (cnt_q == '0) begin
          ack[gid_q] = 1'b1;
        end
`ifndef PISO_TX_ARB_PARITY_EN
        frame_done = (cnt_q == LAST_BIT);
`endif
      end
`ifdef PISO_TX_ARB_PARITY_EN
      ST_PARITY: begin
        serial_out   = par_q;
        serial_valid = 1'b1;
        frame_done   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign grant_id = gid_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Scoreboard bench for piso_tx_arbiter, NUM_REQ=4, WIDTH=4.
// Frames are reassembled off the serial line and matched in order.
module tb_piso_tx_arbiter;

  localparam int N = 4;
  localparam int W = 4;
`ifdef PISO_TX_ARB_PARITY_EN
  localparam int FLEN = W + 1;
`else
  localparam int FLEN = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] data_in = '0;
  logic [N-1:0] ack;
  logic [1:0]   grant_id;
  logic         serial_out;
  logic         serial_valid;
  logic         frame_done;
  logic         busy;

  always #5 clk = ~clk;

  piso_tx_arbiter #(
    .NUM_REQ(N),
    .WIDTH  (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .data_in     (data_in),
    .ack         (ack),
    .grant_id    (grant_id),
    .serial_out  (serial_out),
    .serial_valid(serial_valid),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  typedef struct {
    int           id;
    logic [W-1:0] word;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cyc = 0;
  int nbits = 0;
  int first_gid = 0;
  int t0, t1, t2, t3, t4;
  logic prev_valid = 1'b0;
  logic [FLEN-1:0] bits = '0;
  logic [N-1:0] first_ack = '0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [FLEN-1:0] frame_of(input logic [W-1:0] w);
`ifdef PISO_TX_ARB_PARITY_EN
    return {^w, w};
`else
    return w;
`endif
  endfunction

  always @(posedge clk) cyc++;

  // Serial monitor: rebuild each frame and pop its expectation.
  always @(negedge clk) begin
    if (!rst) begin
      nbits      = 0;
      prev_valid = 1'b0;
    end else begin
      if (serial_valid) begin
        if (nbits == 0) begin
          check("gap", int'(prev_valid), 0);
          first_ack = ack;
          first_gid = int'(grant_id);
        end
        if (nbits < FLEN) bits[nbits] = serial_out;
        nbits++;
        if (frame_done) begin
          done_cyc = cyc;
          check("sb_nonempty", int'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("frame_len", nbits, FLEN);
            check("grant_id", first_gid, e.id);
            check("ack_onehot", int'(first_ack), 1 << e.id);
            check("frame_bits", int'(bits), int'(frame_of(e.word)));
          end
          nbits = 0;
        end
      end else if (nbits != 0) begin
        check("frame_cut", nbits, 0);
        nbits = 0;
      end
      prev_valid = serial_valid;
    end
  end

  task automatic raise(input int id, input logic [W-1:0] w,
                       input bit push);
    data_in[id*W +: W] = w;
    req[id] = 1'b1;
    if (push) sb.push_back('{id, w});
  endtask

  task automatic wait_ack(input int id, output int at);
    at = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ack[id]) begin
        at = cyc;
        req[id] = 1'b0;
        break;
      end
    end
    check($sformatf("ack%0d_seen", id), int'(at >= 0), 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle", int'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ack", int'(ack), 0);
    check("rst_gid", int'(grant_id), 0);
    check("rst_sout", int'(serial_out), 0);
    check("rst_valid", int'(serial_valid), 0);
    check("rst_done", int'(frame_done), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_valid", int'(serial_valid), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_ack", int'(ack), 0);

    raise(0, 4'b1101, 1'b1);
    wait_ack(0, t0);
    wait_idle();

    raise(0, 4'b0110, 1'b1);
    wait_ack(0, t0);
    @(negedge clk);
    raise(3, 4'b1001, 1'b1);
    wait_ack(3, t1);
    check("late_ack", t1 - done_cyc, 2);
    wait_idle();

    raise(0, 4'b0011, 1'b1);
    raise(1, 4'b1010, 1'b1);
    raise(2, 4'b0111, 1'b1);
    raise(3, 4'b1000, 1'b1);
    wait_ack(0, t0);
    wait_ack(1, t1);
    wait_ack(2, t2);
    raise(0, 4'b1110, 1'b1);
    wait_ack(3, t3);
    wait_ack(0, t4);
    check("rr_gap01", t1 - t0, FLEN + 1);
    check("rr_gap12", t2 - t1, FLEN + 1);
    check("rr_gap23", t3 - t2, FLEN + 1);
    check("rr_gap30", t4 - t3, FLEN + 1);
    wait_idle();

    raise(1, 4'b0100, 1'b1);
    wait_ack(1, t0);
    raise(2, 4'b1100, 1'b1);
    raise(0, 4'b0001, 1'b1);
    wait_ack(2, t1);
    wait_ack(0, t2);
    check("fair_gap", t2 - t1, FLEN + 1);
    wait_idle();

    raise(0, 4'b1011, 1'b0);
    wait_ack(0, t0);
    raise(1, 4'b0101, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_valid", int'(serial_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(frame_done), 0);
    check("abort_sout", int'(serial_out), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_ack(1, t1);
    wait_idle();

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_tx_arbiter.md
# piso_tx_arbiter

Transmit controller that shares one parallel-in/serial-out right-shift register among several requesters. It arbitrates round-robin between requesters, loads the winning word into the shift register and shifts it out LSB first. It frames each word with a valid strobe and a completion pulse. It sits between the word producers and the single serial output line.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (≥2)
- WIDTH, 4, bits per word (≥2)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset; clears all state immediately on assertion
- req  in  NUM_REQ  per-requester request, level; held high until the matching ack
- data_in  in  NUM_REQ*WIDTH  word for requester i in bits [i*WIDTH +: WIDTH]; stable while req[i] is high
- ack  out  NUM_REQ  one-hot, one-cycle pulse; the word has been captured
- grant_id  out  $clog2(NUM_REQ)  index of the requester currently being transmitted
- serial_out  out  1  current bit; 0 when not valid
- serial_valid  out  1  high while serial_out carries a frame bit
- frame_done  out  1  one-cycle pulse on the last bit of a frame
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, SHIFT, PARITY (PARITY exists only with the macro).
- IDLE: if any req is high at a clock edge:
  - pick the winner round-robin, searching from last_grant+1 upward with wrap.
  - load data_in of the winner into the shift register.
  - set grant_id and last_grant; clear bit counter; go to SHIFT.
  - with no req, remain in IDLE.
- SHIFT:
  - serial_out = shreg[0]; serial_valid = 1.
  - each edge: shreg shifts right with zero fill; counter increments.
  - on the edge where counter == WIDTH-1: go to PARITY if enabled, else IDLE.
- ack[grant_id] is high during the first SHIFT cycle only.
- frame_done is high during the final frame bit: the last SHIFT cycle, or the PARITY cycle when enabled.
- Requests arriving during SHIFT/PARITY are not sampled; they wait for IDLE.
- A req dropped before its ack is simply not granted. No error is flagged.
- The counter is $clog2(WIDTH+1) bits wide and never wraps within a frame.

## Timing
- Reset values: ack=0, grant_id=0, serial_out=0, serial_valid=0, frame_done=0, busy=0, state=IDLE, last_grant=NUM_REQ-1 (req[0] has first priority), shreg=0.
- Latency: req sampled at edge k, so the first bit and ack are visible in cycle k..k+1.
- Frame occupies WIDTH cycles, or WIDTH+1 with parity.
- Mandatory gap between frames: at least one IDLE cycle with serial_valid=0, even when requests are pending back-to-back.
- Reset asserted mid-frame:
  - all outputs clear immediately.
  - the frame is aborted without frame_done.
  - the interrupted requester was already acked and is not re-sent.
- All outputs are registered or decoded from registered state only. There are no combinational paths from req/data_in to outputs.

## Configuration
- PISO_TX_ARB_PARITY_EN defined:
  - a PARITY state follows the data bits.
  - serial_out in that state = XOR of the captured word (even parity); serial_valid=1; frame_done moves to this cycle.
  - the parity bit is computed at load time and stored.
- Not defined: no PARITY state; frame length is WIDTH; no parity register.

## Structure
- Shared package piso_tx_pkg holds the FSM state enum and a localparam helper for counter width.
- One natural sub-module, piso_shift_core, is the WIDTH-bit right-shift register with load and shift enables and a serial_out of bit 0.
- Arbitration, counter and FSM live in the top module.

## Test plan
All scenarios use NUM_REQ=4, WIDTH=4.
- **Reset:** hold rst=0 for 2 cycles -> all outputs 0, busy=0. Release rst, no req -> outputs stay 0.
- **Single request:** req[0]=1 with word 4'b1101 -> serial_out 1,0,1,1 on four consecutive valid cycles. ack[0] pulses on the first bit, frame_done on the fourth, grant_id=0. With parity, a fifth bit 1 follows, carrying frame_done.
- **Round-robin:** req[3:0]=4'b1111 held, each dropped after its own ack -> grant order 0,1,2,3, then 0 again if re-requested. Exactly one idle cycle separates each frame.
- **Fairness after grant:** req[1] granted, then req[0] and req[2] both high in the next IDLE -> req[2] wins (search starts at 2).
- **Reset mid-frame:** rst=0 during the second bit of a frame -> serial_valid and busy drop to 0 at once, no frame_done. After release, a pending req[1] is granted as the first frame.
- **Late request:** req[3] raised during a frame to req[0] -> not acked until the cycle after that frame's IDLE edge; no bit of either frame is corrupted.
